// File: rtl/fx3_packet_streamer.sv
// Streams fixed-size packets from an upstream sample FIFO to the FX3 GPIF slave interface,
// with an optional idle gap after each packet and a sticky FIFO underrun flag.
module fx3_packet_streamer #(
    parameter int PACKET_WORDS = 8192,
    parameter int COUNT_WIDTH  = 16,
    parameter int GAP_CYCLES   = 0
) (
    input  logic                   inclk,
    input  logic                   reset,
    input  logic                   readData,
    input  logic                   enable,
    input  logic                   clearErrors,
    input  logic [COUNT_WIDTH-1:0] fifoWordCount,
    output logic                   fx3isReading,
    output logic                   lastWord,
    output logic [31:0]            packetCount,
    output logic                   underrunError,
    output logic                   busy
);

    localparam int GAP_WIDTH = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [COUNT_WIDTH-1:0] PACKET_LEN = COUNT_WIDTH'(PACKET_WORDS);
    localparam logic [COUNT_WIDTH-1:0] LAST_INDEX = COUNT_WIDTH'(PACKET_WORDS - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [GAP_WIDTH-1:0]   GAP_LAST   = GAP_WIDTH'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [GAP_WIDTH-1:0]   GAP_ONE    = GAP_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_REQUEST,
        SEND,
        GAP
    } StreamState;

    StreamState             state;
    StreamState             nextState;
    logic                   readDataQ;
    logic [COUNT_WIDTH-1:0] wordCounter;
    logic [COUNT_WIDTH-1:0] nextWordCounter;
    logic [GAP_WIDTH-1:0]   gapCounter;
    logic [GAP_WIDTH-1:0]   nextGapCounter;
    logic [31:0]            nextPacketCount;
    logic                   nextUnderrun;

    always_ff @(posedge inclk) begin
        if (reset) begin
            state         <= IDLE;
            readDataQ     <= 1'b0;
            wordCounter   <= '0;
            gapCounter    <= '0;
            packetCount   <= '0;
            underrunError <= 1'b0;
        end else begin
            state         <= nextState;
            readDataQ     <= readData;
            wordCounter   <= nextWordCounter;
            gapCounter    <= nextGapCounter;
            packetCount   <= nextPacketCount;
            underrunError <= nextUnderrun;
        end
    end

    // Outputs are gated by reset so nothing strobes in the cycle reset is first raised.
    always_comb begin
        nextState       = state;
        nextWordCounter = wordCounter;
        nextGapCounter  = gapCounter;
        nextPacketCount = packetCount;
        nextUnderrun    = underrunError;

        fx3isReading = (state == SEND) && readDataQ && !reset;
        lastWord     = fx3isReading && (wordCounter == LAST_INDEX);
        busy         = ((state == SEND) || (state == GAP)) && !reset;

        case (state)
            IDLE: begin
                if (enable) begin
                    nextState = WAIT_REQUEST;
                end
            end
            WAIT_REQUEST: begin
                if (!enable) begin
                    nextState = IDLE;
                end else if (readDataQ && (fifoWordCount >= PACKET_LEN)) begin
                    nextState = SEND;
                end
            end
            SEND: begin
                if (lastWord) begin
                    nextWordCounter = '0;
                    nextGapCounter  = '0;
                    nextPacketCount = packetCount + 32'd1;
                    nextState       = (GAP_CYCLES > 0) ? GAP : WAIT_REQUEST;
                end else if (fx3isReading) begin
                    nextWordCounter = wordCounter + COUNT_ONE;
                end
            end
            GAP: begin
                if (gapCounter == GAP_LAST) begin
                    nextGapCounter = '0;
                    nextState      = WAIT_REQUEST;
                end else begin
                    nextGapCounter = gapCounter + GAP_ONE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase

        // Setting the flag takes priority over a simultaneous clear.
        if (fx3isReading && (fifoWordCount == '0)) begin
            nextUnderrun = 1'b1;
        end else if (clearErrors) begin
            nextUnderrun = 1'b0;
        end
    end

endmodule

// File: tb/tb_fx3_packet_streamer.sv
// Directed bench for fx3_packet_streamer with 8-word packets and a 2-cycle gap;
// every strobe is matched against a queue of expected lastWord values.
module tb_fx3_packet_streamer;

    localparam int PACKET_WORDS = 8;
    localparam int COUNT_WIDTH  = 16;
    localparam int GAP_CYCLES   = 2;

    logic                   inclk;
    logic                   reset;
    logic                   readData;
    logic                   enable;
    logic                   clearErrors;
    logic [COUNT_WIDTH-1:0] fifoWordCount;
    logic                   fx3isReading;
    logic                   lastWord;
    logic [31:0]            packetCount;
    logic                   underrunError;
    logic                   busy;

    int   checks      = 0;
    int   errors      = 0;
    int   strobeCount = 0;
    logic expQ[$];

    fx3_packet_streamer #(
        .PACKET_WORDS(PACKET_WORDS),
        .COUNT_WIDTH (COUNT_WIDTH),
        .GAP_CYCLES  (GAP_CYCLES)
    ) dut (
        .inclk        (inclk),
        .reset        (reset),
        .readData     (readData),
        .enable       (enable),
        .clearErrors  (clearErrors),
        .fifoWordCount(fifoWordCount),
        .fx3isReading (fx3isReading),
        .lastWord     (lastWord),
        .packetCount  (packetCount),
        .underrunError(underrunError),
        .busy         (busy)
    );

    initial begin
        inclk = 1'b0;
        forever #5 inclk = ~inclk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge inclk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic en, input logic rd, input logic [COUNT_WIDTH-1:0] fifo);
        enable        = en;
        readData      = rd;
        fifoWordCount = fifo;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic pushPacket(input int words);
        for (int i = 0; i < words; i++) begin
            expQ.push_back(i == PACKET_WORDS - 1);
        end
    endtask

    task automatic waitPackets(input logic [31:0] target, input string tag);
        int n = 0;
        while (packetCount !== target && n < 100) begin
            cycle(1);
            n++;
        end
        checkOutput(tag, packetCount, target);
    endtask

    // Each strobe consumes one scoreboard entry; a strobe with nothing queued is itself an error.
    always @(negedge inclk) begin
        if (fx3isReading === 1'b1) begin
            strobeCount++;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $error("[TB] FAIL unexpectedStrobe: observed=strobe expected=none (strobe %0d)", strobeCount);
            end else begin
                logic expLast;
                expLast = expQ.pop_front();
                assert (lastWord === expLast) else begin
                    errors++;
                    $error("[TB] FAIL lastWord: observed=%0b expected=%0b (strobe %0d)", lastWord, expLast, strobeCount);
                end
            end
        end
    end

    initial begin
        reset       = 1'b1;
        clearErrors = 1'b0;
        applyStimulus(1'b0, 1'b0, '0);
        cycle(2);
        checkOutput("resetStrobe", 32'(fx3isReading), 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetCount", packetCount, 32'd0);
        checkOutput("resetUnderrun", 32'(underrunError), 32'd0);
        reset = 1'b0;
        cycle(1);
        checkOutput("releaseBusy", 32'(busy), 32'd0);
        checkOutput("releaseStrobe", 32'(fx3isReading), 32'd0);

        $display("[TB] continuous packet with gap");
        applyStimulus(1'b1, 1'b1, 16'd20);
        pushPacket(PACKET_WORDS);
        waitPackets(32'd1, "firstPacket");
        checkOutput("gap1Busy", 32'(busy), 32'd1);
        checkOutput("gap1Strobe", 32'(fx3isReading), 32'd0);
        pushPacket(PACKET_WORDS);
        cycle(1);
        checkOutput("gap2Busy", 32'(busy), 32'd1);
        cycle(1);
        checkOutput("afterGapBusy", 32'(busy), 32'd0);
        cycle(1);
        checkOutput("secondStart", 32'(fx3isReading), 32'd1);
        cycle(2);
        enable = 1'b0;
        waitPackets(32'd2, "secondPacket");
        cycle(20);
        checkOutput("noMorePackets", packetCount, 32'd2);
        checkOutput("strobesAfterTwo", 32'(strobeCount), 32'd16);
        checkOutput("idleBusy", 32'(busy), 32'd0);

        $display("[TB] stall after word 4");
        pushPacket(PACKET_WORDS);
        enable = 1'b1;
        cycle(5);
        checkOutput("word4Strobe", 32'(fx3isReading), 32'd1);
        readData = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle(1);
            checkOutput("stallStrobe", 32'(fx3isReading), 32'd0);
            checkOutput("stallBusy", 32'(busy), 32'd1);
        end
        readData = 1'b1;
        cycle(1);
        checkOutput("resumeStrobe", 32'(fx3isReading), 32'd1);
        checkOutput("strobesBeforeResume", 32'(strobeCount), 32'd20);
        enable = 1'b0;
        waitPackets(32'd3, "stalledPacket");
        cycle(5);
        checkOutput("strobesAfterStall", 32'(strobeCount), 32'd24);

        $display("[TB] fifo threshold and underrun");
        applyStimulus(1'b1, 1'b1, 16'd7);
        cycle(10);
        checkOutput("belowThresholdBusy", 32'(busy), 32'd0);
        checkOutput("belowThresholdStrobes", 32'(strobeCount), 32'd24);
        pushPacket(PACKET_WORDS);
        fifoWordCount = 16'd8;
        cycle(1);
        checkOutput("thresholdStart", 32'(fx3isReading), 32'd1);
        checkOutput("noUnderrunYet", 32'(underrunError), 32'd0);
        cycle(2);
        fifoWordCount = '0;
        cycle(1);
        checkOutput("underrunSet", 32'(underrunError), 32'd1);
        applyStimulus(1'b0, 1'b1, 16'd8);
        waitPackets(32'd4, "underrunPacket");
        cycle(1);
        checkOutput("underrunSticky", 32'(underrunError), 32'd1);
        clearErrors = 1'b1;
        cycle(1);
        clearErrors = 1'b0;
        checkOutput("underrunCleared", 32'(underrunError), 32'd0);

        $display("[TB] reset mid-packet");
        cycle(5);
        applyStimulus(1'b1, 1'b1, 16'd20);
        pushPacket(4);
        cycle(5);
        checkOutput("preResetStrobe", 32'(fx3isReading), 32'd1);
        cycle(1);
        reset = 1'b1;
        #1;
        checkOutput("resetCycleStrobe", 32'(fx3isReading), 32'd0);
        checkOutput("resetCycleBusy", 32'(busy), 32'd0);
        cycle(1);
        checkOutput("midResetCount", packetCount, 32'd0);
        checkOutput("midResetStrobe", 32'(fx3isReading), 32'd0);
        reset = 1'b0;
        cycle(1);
        checkOutput("postReleaseBusy", 32'(busy), 32'd0);
        checkOutput("postReleaseStrobe", 32'(fx3isReading), 32'd0);
        pushPacket(PACKET_WORDS);
        cycle(1);
        checkOutput("postResetStart", 32'(fx3isReading), 32'd1);
        enable = 1'b0;
        waitPackets(32'd1, "postResetPacket");
        cycle(6);
        checkOutput("totalStrobes", 32'(strobeCount), 32'd44);
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
        checkOutput("finalBusy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
